prog_ram_loader: RTL and testbench
==================================

# prog_ram_loader

Writable 16×8 program memory with a switch/pushbutton loader. It replaces the fixed instruction ROM on the CPU fetch port: the CPU reads it combinationally by address, and the operator writes it one byte at a time. Each byte is entered as two 4-bit switch nibbles, each confirmed with a debounced button press. While loading, the block holds the CPU and drives the 7-segment nibble with loader status.

## Interface
- DEBOUNCE_CYCLES, 120000 — consecutive synchronized-stable cycles required to accept a button level change (10 ms at 12 MHz).
- clk  in  1  — system clock.
- reset  in  1  — asynchronous, active-high; clears all state.
- load_mode  in  1  — raw level; 1 = load, 0 = run.
- btn_enter  in  1  — raw pushbutton, active-high, bouncy.
- switch  in  4  — raw nibble entry switches.
- cpu_addr  in  4  — CPU fetch address.
- cpu_data  out  8  — instruction at cpu_addr.
- cpu_hold  out  1  — 1 = CPU must hold in reset (any load state).
- disp_nibble  out  4  — value for the 7-segment decoder.
- phase  out  1  — 0 = expecting high nibble, 1 = expecting low nibble.

## Operation
- Inputs load_mode, btn_enter and switch[3:0] each pass through a 2-flop synchronizer. Only the synchronized copies are used.
- Debounce:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - The counter clears whenever sync_btn equals btn_stable; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, btn_stable takes sync_btn and the counter clears.
  - A btn_stable 0→1 transition produces a one-cycle press pulse.
- Memory: 16 × 8 flops. Reset contents are all 8'h00 unless the macro is defined (see Configuration).
- FSM states RUN, LOAD_HI, LOAD_LO; reset state is RUN.
  - RUN: if sync load_mode = 1, go to LOAD_HI and set wr_addr := 0.
  - LOAD_HI: on press, hi := sync switch and go to LOAD_LO.
  - LOAD_LO: on press, mem[wr_addr] := {hi, sync switch}, wr_addr := wr_addr+1, go to LOAD_HI. wr_addr wraps 15→0, so a 17th byte overwrites address 0.
  - Either load state with sync load_mode = 0: go to RUN. A pending high nibble is discarded and nothing is written.
  - load_mode drop and press in the same cycle: the mode drop wins and no write occurs.
- cpu_data:
  - In RUN, cpu_data = mem[cpu_addr], combinational.
  - Otherwise it is forced to 8'h00 (NOP).
- cpu_hold = (state != RUN), registered state decode.
- disp_nibble:
  - RUN: 4'h0.
  - LOAD_HI: wr_addr.
  - LOAD_LO: hi.
- phase = (state == LOAD_LO).
- Reset values: state RUN, wr_addr 0, hi 0, btn_stable 0, counter 0, all synchronizers 0.
  - Outputs after reset: cpu_hold 0, phase 0, disp_nibble 0, cpu_data = reset memory image at cpu_addr.
- Reset asserted mid-load: immediate return to RUN. Memory is reinitialized and the partial entry is lost.

## Timing
- A clean raw btn_enter rising edge at cycle t produces the press pulse in cycle t+2+DEBOUNCE_CYCLES.
- The memory write (or hi capture) occurs at the clock edge ending the pulse cycle.
- A button pulse shorter than DEBOUNCE_CYCLES synchronized cycles produces no press.
- Release also needs DEBOUNCE_CYCLES stable cycles. A second press requires a full release first.
- switch is sampled from its synchronized copy in the pulse cycle. It must be stable for at least 3 cycles before the pulse.
- load_mode change to cpu_hold change: 3 cycles (2 sync + 1 state register).
- cpu_data has zero-cycle latency from cpu_addr in RUN. A byte written in LOAD_LO is readable in the first RUN cycle after exit.

## Configuration
- LOADER_DEFAULT_PROG_EN defined: reset loads the demo program at addresses 0–6:
  - 8'hBC, 8'h43, 8'h90, 8'h86, 8'hA0, 8'h1C, 8'h90.
  - Addresses 7–15 are 8'h00.
- Not defined: reset clears all 16 words to 8'h00.
- No other behaviour differs.

## Test plan
- Reset (DEBOUNCE_CYCLES=4, macro off) → cpu_hold=0, phase=0, disp_nibble=0, cpu_data=8'h00 for all 16 cpu_addr. With macro on → cpu_addr 0 reads 8'hBC and cpu_addr 6 reads 8'h90.
- Load then run:
  - load_mode=1; press with switch 4,3 then 9,0; load_mode=0.
  - Expect mem[0]=8'h43 and mem[1]=8'h90.
  - Expect cpu_hold rising and falling exactly 3 cycles after each load_mode edge, and cpu_data=8'h00 while held.
- Bounce rejection:
  - btn_enter high 2 cycles, low 2 cycles, repeated 5 times → no phase change.
  - Then held 10 cycles → exactly one press, phase=1, disp_nibble=entered hi.
- Wrap: enter 17 bytes 8'h10..8'h20 → mem[0]=8'h20, mem[1]=8'h11, mem[15]=8'h1F. disp_nibble shows 1 in LOAD_HI after the 17th write.
- Abort: in LOAD_LO after hi=4'hA, drop load_mode → no write, state RUN. Re-entering load shows disp_nibble=0 and phase=0.
- Reset mid-load: assert reset in LOAD_LO after two bytes written → cpu_hold=0 immediately and mem returns to the reset image.

Source files
------------

// File: rtl/prog_ram_loader_if.sv
// CPU fetch port of the writable program memory: address in, instruction and
// hold out. The CPU side uses the master modport, the loader the slave modport.
interface prog_ram_loader_if;
   logic [3:0] cpu_addr;
   logic [7:0] cpu_data;
   logic       cpu_hold;

   modport master (output cpu_addr, input  cpu_data, input  cpu_hold);
   modport slave  (input  cpu_addr, output cpu_data, output cpu_hold);
endinterface

// File: rtl/prog_ram_loader.sv
// 16x8 program memory with a switch/pushbutton byte loader.
// Each byte is entered as two debounced nibble presses; while loading the CPU
// is held and sees NOPs. Define LOADER_DEFAULT_PROG_EN to reset the memory to
// the demo program instead of all zeros.
module prog_ram_loader #(
   parameter int DEBOUNCE_CYCLES = 120000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load_mode,
   input  logic                   btn_enter,
   input  logic [3:0]             switch,
   prog_ram_loader_if.slave       cpu,
   output logic [3:0]             disp_nibble,
   output logic                   phase
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

`ifdef LOADER_DEFAULT_PROG_EN
   localparam logic [15:0][7:0] RST_IMAGE =
      {72'h0, 8'h90, 8'h1C, 8'hA0, 8'h86, 8'h90, 8'h43, 8'hBC};
`else
   localparam logic [15:0][7:0] RST_IMAGE = '0;
`endif

   typedef enum logic [1:0] {RUN, LOAD_HI, LOAD_LO} state_t;

   state_t            state_q, state_d;
   logic [5:0]        sync1_q, sync2_q;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              stable_q, stable_d;
   logic              stable_prev_q;
   logic [3:0]        wr_addr_q, wr_addr_d;
   logic [3:0]        hi_q, hi_d;
   logic [15:0][7:0]  mem_q, mem_d;

   logic              sync_mode, sync_btn, press;
   logic [3:0]        sync_sw;

   assign sync_mode = sync2_q[5];
   assign sync_btn  = sync2_q[4];
   assign sync_sw   = sync2_q[3:0];
   // One-cycle pulse in the first cycle the debounced level reads high.
   assign press     = stable_q & ~stable_prev_q;

   // Two-flop synchronizers for all raw operator inputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {load_mode, btn_enter, switch};
         sync2_q <= sync1_q;
      end
   end

   // Debounce: a level change is accepted after DEBOUNCE_CYCLES differing cycles.
   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (sync_btn == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         stable_d = sync_btn;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Debounce and press-edge registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q         <= '0;
         stable_q      <= 1'b0;
         stable_prev_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         stable_q      <= stable_d;
         stable_prev_q <= stable_q;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   // FSM next state: dropping load_mode always wins over a press.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (sync_mode) state_d = LOAD_HI;
         LOAD_HI: if (!sync_mode) state_d = RUN;
                  else if (press) state_d = LOAD_LO;
         LOAD_LO: if (!sync_mode) state_d = RUN;
                  else if (press) state_d = LOAD_HI;
         default: state_d = RUN;
      endcase
   end

   // Loader datapath: nibble capture, memory write and write-address advance.
   always_comb begin
      wr_addr_d = wr_addr_q;
      hi_d      = hi_q;
      mem_d     = mem_q;
      case (state_q)
         RUN:     if (sync_mode) wr_addr_d = 4'd0;
         LOAD_HI: if (sync_mode && press) hi_d = sync_sw;
         LOAD_LO: if (sync_mode && press) begin
                     mem_d[wr_addr_q] = {hi_q, sync_sw};
                     wr_addr_d        = wr_addr_q + 4'd1;
                  end
         default: ;
      endcase
   end

   // Loader datapath registers; reset restores the memory image.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_addr_q <= 4'd0;
         hi_q      <= 4'd0;
         mem_q     <= RST_IMAGE;
      end else begin
         wr_addr_q <= wr_addr_d;
         hi_q      <= hi_d;
         mem_q     <= mem_d;
      end
   end

   // Outputs decoded from the registered state.
   always_comb begin
      cpu.cpu_hold = (state_q != RUN);
      phase        = (state_q == LOAD_LO);
      cpu.cpu_data = (state_q == RUN) ? mem_q[cpu.cpu_addr] : 8'h00;
      case (state_q)
         LOAD_HI: disp_nibble = wr_addr_q;
         LOAD_LO: disp_nibble = hi_q;
         default: disp_nibble = 4'h0;
      endcase
   end

endmodule

// File: tb/tb_prog_ram_loader.sv
// Directed bench for prog_ram_loader with DEBOUNCE_CYCLES = 4.
module tb_prog_ram_loader;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       load_mode = 1'b0;
   logic       btn_enter = 1'b0;
   logic [3:0] switch = 4'h0;
   logic [3:0] disp_nibble;
   logic       phase;
   int         n_tests = 0;
   int         n_fail = 0;
   logic [7:0] img [16];

   prog_ram_loader_if bus ();

   prog_ram_loader #(.DEBOUNCE_CYCLES(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .load_mode   (load_mode),
      .btn_enter   (btn_enter),
      .switch      (switch),
      .cpu         (bus),
      .disp_nibble (disp_nibble),
      .phase       (phase)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance n clocks, landing 1 time unit after the last rising edge.
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Clean press-and-release with switch settled beforehand.
   task automatic press(input logic [3:0] sw);
      switch = sw;
      cyc(3);
      btn_enter = 1'b1;
      cyc(8);
      btn_enter = 1'b0;
      cyc(8);
   endtask

   task automatic load_byte(input logic [7:0] b);
      press(b[7:4]);
      press(b[3:0]);
   endtask

   task automatic read(input string tag, input logic [3:0] a, input logic [7:0] exp);
      bus.cpu_addr = a;
      #1;
      check(tag, bus.cpu_data, exp);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) img[i] = 8'h00;
`ifdef LOADER_DEFAULT_PROG_EN
      img[0] = 8'hBC; img[1] = 8'h43; img[2] = 8'h90; img[3] = 8'h86;
      img[4] = 8'hA0; img[5] = 8'h1C; img[6] = 8'h90;
`endif
      bus.cpu_addr = 4'h0;
      cyc(3);
      reset = 1'b0;
      cyc(1);

      // Reset state
      check("rst_hold", 8'(bus.cpu_hold), 8'h0);
      check("rst_phase", 8'(phase), 8'h0);
      check("rst_disp", 8'(disp_nibble), 8'h0);
      for (int a = 0; a < 16; a++) read($sformatf("rst_mem%0d", a), 4'(a), img[a]);

      // Load entry: cpu_hold rises on the third edge after load_mode
      load_mode = 1'b1;
      cyc(1); check("hold_up_c1", 8'(bus.cpu_hold), 8'h0);
      cyc(1); check("hold_up_c2", 8'(bus.cpu_hold), 8'h0);
      cyc(1); check("hold_up_c3", 8'(bus.cpu_hold), 8'h1);
      press(4'h4);
      check("hi_phase", 8'(phase), 8'h1);
      check("hi_disp", 8'(disp_nibble), 8'h4);
      press(4'h3);
      load_byte(8'h90);
      check("ld_phase", 8'(phase), 8'h0);
      check("ld_disp_addr", 8'(disp_nibble), 8'h2);
      read("held_nop", 4'h0, 8'h00);

      // Exit: cpu_hold falls on the third edge
      load_mode = 1'b0;
      cyc(1); check("hold_dn_c1", 8'(bus.cpu_hold), 8'h1);
      cyc(1); check("hold_dn_c2", 8'(bus.cpu_hold), 8'h1);
      cyc(1); check("hold_dn_c3", 8'(bus.cpu_hold), 8'h0);
      read("run_mem0", 4'h0, 8'h43);
      read("run_mem1", 4'h1, 8'h90);
      read("run_mem2", 4'h2, img[2]);

      // Bounce rejection: 2-high/2-low chatter never reaches the threshold
      load_mode = 1'b1;
      switch = 4'hA;
      cyc(5);
      for (int k = 0; k < 5; k++) begin
         btn_enter = 1'b1; cyc(2);
         btn_enter = 1'b0; cyc(2);
      end
      cyc(4);
      check("bounce_phase", 8'(phase), 8'h0);
      btn_enter = 1'b1; cyc(10);
      btn_enter = 1'b0; cyc(8);
      check("held_phase", 8'(phase), 8'h1);
      check("held_disp", 8'(disp_nibble), 8'hA);

      // Abort in LOAD_LO with hi = A: nothing written
      load_mode = 1'b0;
      cyc(4);
      check("abort_hold", 8'(bus.cpu_hold), 8'h0);
      read("abort_mem0", 4'h0, 8'h43);
      load_mode = 1'b1;
      cyc(4);
      check("reent_disp", 8'(disp_nibble), 8'h0);
      check("reent_phase", 8'(phase), 8'h0);

      // Wrap: 17 bytes 10..20, the last overwrites address 0
      for (int i = 0; i < 17; i++) load_byte(8'(8'h10 + i));
      check("wrap_disp", 8'(disp_nibble), 8'h1);
      check("wrap_phase", 8'(phase), 8'h0);
      load_mode = 1'b0;
      cyc(4);
      read("wrap_mem0", 4'h0, 8'h20);
      read("wrap_mem1", 4'h1, 8'h11);
      read("wrap_mem7", 4'h7, 8'h17);
      read("wrap_mem15", 4'hF, 8'h1F);

      // Reset mid-load: two bytes written, then reset in LOAD_LO
      load_mode = 1'b1;
      cyc(4);
      load_byte(8'h55);
      load_byte(8'h66);
      press(4'h7);
      check("mid_phase", 8'(phase), 8'h1);
      #2;
      reset = 1'b1;
      load_mode = 1'b0;
      #1;
      check("mid_rst_hold", 8'(bus.cpu_hold), 8'h0);
      check("mid_rst_phase", 8'(phase), 8'h0);
      check("mid_rst_disp", 8'(disp_nibble), 8'h0);
      cyc(2);
      reset = 1'b0;
      cyc(2);
      for (int a = 0; a < 16; a++) read($sformatf("mid_rst_mem%0d", a), 4'(a), img[a]);
      check("post_rst_hold", 8'(bus.cpu_hold), 8'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
